rtc_bus_sequencer: RTL and testbench



---
 rtl/rtc_bus_pkg.sv | 16 +
 rtl/rtc_bus_sequencer_if.sv | 20 ++
 rtl/rtc_phase_timer.sv | 20 ++
 rtl/rtc_bus_sequencer.sv | 123 ++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC parallel-bus sequencer.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE
  } state_t;

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 4;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GAP_DEF   = 4;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Controller-side request/response plus pad-side bus signals of the sequencer.
interface rtc_bus_sequencer_if;
  logic       req_wr, req_rd;
  logic [7:0] addr, wdata;
  logic       busy, done;
  logic [7:0] rdata;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;
  logic       cs, rd, wr, ad;

  modport slave (
    input  req_wr, req_rd, addr, wdata, bus_in,
    output busy, done, rdata, bus_out, bus_oe, cs, rd, wr, ad
  );
  modport master (
    output req_wr, req_rd, addr, wdata, bus_in,
    input  busy, done, rdata, bus_out, bus_oe, cs, rd, wr, ad
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter; zero flags the last cycle of a timed phase.
module rtc_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data transaction sequencer for the RTC parallel bus.
// Define RTC_IN_SYNC_EN to pass bus_in through a 2-flop synchronizer (reads +2 cycles).
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_sequencer_if.slave sif
);
  state_t           state, nxt;
  op_t              op_q, nxt_op;
  logic [7:0]       addr_q, wdata_q, nxt_addr, nxt_wdata, cap;
  logic             load, zero;
  logic [CNT_W-1:0] load_val;
  logic             a_ph, d_ph, n_cs, n_rd, n_wr, n_ad, n_oe, n_busy, n_done;
  logic [7:0]       n_bus;

`ifdef RTC_IN_SYNC_EN
  localparam int RD_EXT = 2;
  logic [7:0] sync1, sync2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sif.bus_in;
      sync2 <= sync1;
    end
  end
  assign cap = sync2;
`else
  localparam int RD_EXT = 0;
  assign cap = sif.bus_in;
`endif

  rtc_phase_timer #(.W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .zero(zero)
  );

  always_comb begin
    nxt       = state;
    nxt_op    = op_q;
    nxt_addr  = addr_q;
    nxt_wdata = wdata_q;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      IDLE: if (sif.req_wr || sif.req_rd) begin
        nxt       = A_SETUP;
        nxt_op    = sif.req_wr ? OP_WR : OP_RD;
        nxt_addr  = sif.addr;
        nxt_wdata = sif.wdata;
        load      = 1'b1;
        load_val  = CNT_W'(T_SETUP - 1);
      end
      A_SETUP: if (zero) begin nxt = A_PULSE; load = 1'b1; load_val = CNT_W'(T_PULSE - 1); end
      A_PULSE: if (zero) begin nxt = A_HOLD;  load = 1'b1; load_val = CNT_W'(T_HOLD - 1);  end
      A_HOLD:  if (zero) begin nxt = GAP;     load = 1'b1; load_val = CNT_W'(T_GAP - 1);   end
      GAP:     if (zero) begin nxt = D_SETUP; load = 1'b1; load_val = CNT_W'(T_SETUP - 1); end
      D_SETUP: if (zero) begin
        nxt      = D_PULSE;
        load     = 1'b1;
        load_val = (op_q == OP_RD) ? CNT_W'(T_PULSE + RD_EXT - 1) : CNT_W'(T_PULSE - 1);
      end
      D_PULSE: if (zero) begin nxt = D_HOLD;  load = 1'b1; load_val = CNT_W'(T_HOLD - 1);  end
      D_HOLD:  if (zero) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with state.
  always_comb begin
    a_ph   = (nxt == A_SETUP) || (nxt == A_PULSE) || (nxt == A_HOLD);
    d_ph   = (nxt == D_SETUP) || (nxt == D_PULSE) || (nxt == D_HOLD);
    n_cs   = !((nxt == A_PULSE) || (nxt == D_PULSE));
    n_wr   = !((nxt == A_PULSE) || ((nxt == D_PULSE) && (nxt_op == OP_WR)));
    n_rd   = !((nxt == D_PULSE) && (nxt_op == OP_RD));
    n_ad   = !a_ph;
    n_oe   = a_ph || (d_ph && (nxt_op == OP_WR));
    n_bus  = a_ph ? nxt_addr : ((d_ph && (nxt_op == OP_WR)) ? nxt_wdata : 8'h00);
    n_busy = (nxt != IDLE);
    n_done = (nxt == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= OP_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      sif.cs      <= 1'b1;
      sif.rd      <= 1'b1;
      sif.wr      <= 1'b1;
      sif.ad      <= 1'b1;
      sif.bus_oe  <= 1'b0;
      sif.bus_out <= '0;
      sif.busy    <= 1'b0;
      sif.done    <= 1'b0;
      sif.rdata   <= '0;
    end else begin
      state       <= nxt;
      op_q        <= nxt_op;
      addr_q      <= nxt_addr;
      wdata_q     <= nxt_wdata;
      sif.cs      <= n_cs;
      sif.rd      <= n_rd;
      sif.wr      <= n_wr;
      sif.ad      <= n_ad;
      sif.bus_oe  <= n_oe;
      sif.bus_out <= n_bus;
      sif.busy    <= n_busy;
      sif.done    <= n_done;
      // Capture at the edge closing the read strobe, while rd is still low on the pads.
      if (state == D_PULSE && zero && op_q == OP_RD) sif.rdata <= cap;
    end
  end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: reset, write, read, priority, busy-ignore, back-to-back.
module tb_rtc_bus_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_bus_sequencer_if bif();
  rtc_bus_sequencer dut (.clk(clk), .reset(reset), .sif(bif));

`ifdef RTC_IN_SYNC_EN
  localparam int EXT = 2;
`else
  localparam int EXT = 0;
`endif

  logic [7:0] rd_byte;
  assign bif.bus_in = (bif.rd == 1'b0) ? rd_byte : 8'hA5;

  int checks = 0, failures = 0;
  int aw_lo, dw_lo, drd_lo, rd_any, wr_data, done_at, idle_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and take the accepting edge; returns at cycle 1 of the transaction.
  task automatic start(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    bif.req_wr = w;
    bif.req_rd = r;
    bif.addr   = a;
    bif.wdata  = d;
    tick();
  endtask

  task automatic wait_done(input logic [7:0] a, input logic [7:0] d, input bit tog);
    aw_lo = 0; dw_lo = 0; drd_lo = 0; rd_any = 0; wr_data = 0; idle_cnt = 0; done_at = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (tog) bif.req_rd = cyc[0];
      if (!bif.ad && !bif.wr && !bif.cs && bif.bus_oe && bif.bus_out == a) aw_lo++;
      if (bif.ad && !bif.wr && !bif.cs && bif.bus_oe && bif.bus_out == d) dw_lo++;
      if (bif.ad && !bif.rd && !bif.cs && !bif.bus_oe) drd_lo++;
      if (!bif.rd) rd_any++;
      if (bif.ad && !bif.wr) wr_data++;
      if (!bif.busy) idle_cnt++;
      if (bif.done) begin done_at = cyc; break; end
      tick();
    end
    if (tog) bif.req_rd = 1'b0;
  endtask

  always @(negedge clk) if (!reset) begin
    checks++;
    assert (!(bif.rd == 1'b0 && bif.wr == 1'b0) && !(bif.bus_oe && bif.rd == 1'b0)) else begin
      failures++;
      $error("FAIL strobe_conflict observed=rd%b wr%b oe%b expected=no_overlap", bif.rd, bif.wr, bif.bus_oe);
    end
  end

  initial begin
    reset = 1'b1;
    bif.req_wr = 0; bif.req_rd = 0; bif.addr = 0; bif.wdata = 0;
    rd_byte = 8'h12;
    tick(); tick();
    chk("rst_cs", bif.cs, 1);       chk("rst_rd", bif.rd, 1);
    chk("rst_wr", bif.wr, 1);       chk("rst_ad", bif.ad, 1);
    chk("rst_oe", bif.bus_oe, 0);   chk("rst_bus", bif.bus_out, 0);
    chk("rst_busy", bif.busy, 0);   chk("rst_done", bif.done, 0);
    chk("rst_rdata", bif.rdata, 0);
    reset = 1'b0;
    tick();

    // Write 0x59 to 0x21
    start(1, 0, 8'h21, 8'h59);
    bif.req_wr = 0;
    chk("wr_busy1", bif.busy, 1);
    wait_done(8'h21, 8'h59, 0);
    chk("wr_done_at", done_at, 21);
    chk("wr_addr_lo", aw_lo, 4);
    chk("wr_data_lo", dw_lo, 4);
    chk("wr_rd_never", rd_any, 0);
    chk("wr_busy_all", idle_cnt, 0);
    tick();
    chk("wr_idle_busy", bif.busy, 0);
    chk("wr_idle_done", bif.done, 0);
    chk("wr_rdata_keep", bif.rdata, 0);

    // Read 0x22, bus returns 0x12
    start(0, 1, 8'h22, 8'h00);
    bif.req_rd = 0;
    wait_done(8'h22, 8'h00, 0);
    chk("rd_done_at", done_at, 21 + EXT);
    chk("rd_addr_lo", aw_lo, 4);
    chk("rd_data_lo", drd_lo, 4 + EXT);
    chk("rd_no_wr_data", wr_data, 0);
    chk("rd_rdata", bif.rdata, 8'h12);
    tick();
    chk("rd_idle_busy", bif.busy, 0);

    // Both requests together: write wins
    start(1, 1, 8'h30, 8'h77);
    bif.req_wr = 0; bif.req_rd = 0;
    wait_done(8'h30, 8'h77, 0);
    chk("both_done_at", done_at, 21);
    chk("both_wr_lo", dw_lo, 4);
    chk("both_rd_never", rd_any, 0);
    chk("both_rdata_keep", bif.rdata, 8'h12);
    tick();

    // req_rd toggling while busy is ignored
    start(1, 0, 8'h40, 8'h41);
    bif.req_wr = 0;
    wait_done(8'h40, 8'h41, 1);
    chk("tog_done_at", done_at, 21);
    chk("tog_rd_never", rd_any, 0);
    tick();
    chk("tog_idle", bif.busy, 0);
    tick();
    chk("tog_no_start", bif.busy, 0);

    // Held request: second transaction starts right after the IDLE cycle
    start(1, 0, 8'h50, 8'h51);
    wait_done(8'h50, 8'h51, 0);
    chk("hold1_done_at", done_at, 21);
    tick();
    chk("hold_idle", bif.busy, 0);
    tick();
    chk("hold_restart", bif.busy, 1);
    bif.req_wr = 0;
    wait_done(8'h50, 8'h51, 0);
    chk("hold2_done_at", done_at, 21);
    chk("hold2_wr_lo", dw_lo, 4);
    tick();

    // Asynchronous reset in the middle of the address strobe
    start(1, 0, 8'h60, 8'h61);
    bif.req_wr = 0;
    tick(); tick();
    chk("mid_cs_low", bif.cs, 0);
    chk("mid_wr_low", bif.wr, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_cs", bif.cs, 1);      chk("mid_wr", bif.wr, 1);
    chk("mid_busy", bif.busy, 0);  chk("mid_oe", bif.bus_oe, 0);
    chk("mid_ad", bif.ad, 1);      chk("mid_rdata", bif.rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", bif.busy, 0);
    rd_byte = 8'h9C;
    start(0, 1, 8'h23, 8'h00);
    bif.req_rd = 0;
    wait_done(8'h23, 8'h00, 0);
    chk("post_done_at", done_at, 21 + EXT);
    chk("post_rdata", bif.rdata, 8'h9C);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
